fifo_unpacker: RTL and testbench
================================

FIFO_UNPACKER -- requirements
Module: fifo_unpacker

Interface
REQ-001 SHALL have parameter BEAT_W, default 16: output beat width; legal values 8, 16, 32.
REQ-002 SHALL derive localparam BEATS = 64/BEAT_W, the beats per FIFO word.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-low reset; asserted when rst=0 at a clk edge.
REQ-005 SHALL have port fifo_data  input  64: head word of the upstream 4-entry FIFO; valid when fifo_empty=0.
REQ-006 SHALL have port fifo_empty  input  1: upstream FIFO holds no words.
REQ-007 SHALL have port fifo_err  input  1: upstream FIFO error flag.
REQ-008 SHALL have port pop_fifo  output  1: one-cycle request to consume the head word.
REQ-009 SHALL have port out_data  output  BEAT_W: current beat.
REQ-010 SHALL have port out_valid  output  1: out_data is valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts a beat when high together with out_valid.
REQ-012 SHALL have port busy  output  1: a word is held or is being sent.
REQ-013 SHALL have port err  output  1: sticky error indication.

Function
REQ-014 SHALL implement the states IDLE, SEND and ERR, with a 64-bit shift register and a beat counter of width clog2(BEATS).
REQ-015 In IDLE with fifo_empty=0, SHALL drive pop_fifo=1 combinationally, capture fifo_data, set the counter to 0 and go to SEND on the same edge.
REQ-016 In IDLE with fifo_empty=1, SHALL hold pop_fifo=0 and stay in IDLE.
REQ-017 In SEND, SHALL drive out_valid=1 and out_data = shift register bits [BEAT_W-1:0], sending least significant beat first.
REQ-018 In SEND with out_ready=0, SHALL hold out_data, the counter and the state unchanged (no beat dropped).
REQ-019 On a beat accepted while counter < BEATS-1, SHALL shift the register right by BEAT_W and increment the counter.
REQ-020 On acceptance of the last beat with fifo_empty=0, SHALL assert pop_fifo, reload from fifo_data, clear the counter and stay in SEND, giving no bubble between words.
REQ-021 On acceptance of the last beat with fifo_empty=1, SHALL return to IDLE.
REQ-022 Latency SHALL be one cycle: a pop at edge N produces out_valid=1 in cycle N+1; throughput is one beat per cycle.
REQ-023 SHALL assert pop_fifo at most once per word and never while fifo_empty=1.
REQ-024 With fifo_err=1 in any state, SHALL go to ERR on the next edge; this takes priority over pop and reload.
REQ-025 In ERR, SHALL hold err=1, out_valid=0 and pop_fifo=0 until reset.
REQ-026 SHALL drive busy=1 in SEND and busy=0 in IDLE and ERR.

Reset
REQ-027 With rst=0 at an edge, SHALL enter IDLE and clear the shift register and counter, regardless of state or mid-word position; the partial word is discarded.
REQ-028 Reset values SHALL be: out_valid=0, out_data=0, busy=0, err=0.
REQ-029 During reset, SHALL force pop_fifo=0 regardless of fifo_empty.

Configuration
REQ-030 With macro FIFO_UNPACKER_LAST_EN defined, SHALL add output port out_last (1 bit), equal to 1 exactly when out_valid=1 and counter = BEATS-1; its reset value is 0.
REQ-031 With FIFO_UNPACKER_LAST_EN undefined, port out_last and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 SHALL take the state encoding (IDLE=2'b00, SEND=2'b01, ERR=2'b10) and the FIFO word width constant (64) from shared package fifo_pkg, which the FIFO also uses.
REQ-033 SHALL build all state, shift-register and counter flops from the codebase dff cell (one instance array per register), with next-state logic in a single combinational block.
REQ-034 SHALL contain no other sub-modules.

Verification
REQ-035 Reset idle: hold rst=0 for 2 cycles with fifo_empty=0 -> pop_fifo=0, out_valid=0 and err=0 throughout; first pop occurs in the first cycle after rst=1.
REQ-036 Single word: fifo_data=64'h4444_3333_2222_1111 with fifo_empty dropping to 1 after the pop, out_ready=1 -> beats 1111, 2222, 3333, 4444 on consecutive cycles, then IDLE and busy=0.
REQ-037 Back-to-back: two words available, out_ready=1 -> 8 consecutive valid beats with no gap and pop_fifo pulsed exactly twice, the second in the cycle of beat 4.
REQ-038 Backpressure: out_ready=0 for 3 cycles on beat 2 -> out_data stays at 2222 and out_valid stays 1 throughout; the sequence resumes intact.
REQ-039 Error: fifo_err=1 during beat 3 -> next cycle err=1 and out_valid=0; no further pops until reset clears err.
REQ-040 With FIFO_UNPACKER_LAST_EN and BEAT_W=32: one word -> 2 beats, with out_last=0 on the first beat and out_last=1 on the second.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO word width and unpacker state encoding
package fifo_pkg;
  localparam int FIFO_W = 64;
  typedef enum logic [1:0] {IDLE = 2'b00, SEND = 2'b01, ERR = 2'b10} state_t;
endpackage

// File: rtl/dff.sv
// dff: single-bit flop, synchronous active-low reset to zero
module dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  // register d, clearing on reset
  always_ff @(posedge clk) q <= !rst ? 1'b0 : d;
endmodule

// File: rtl/fifo_unpacker.sv
// fifo_unpacker: splits 64-bit FIFO words into BEAT_W beats, LSB first; FIFO_UNPACKER_LAST_EN adds out_last
module fifo_unpacker
  import fifo_pkg::*;
#(
  parameter int BEAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FIFO_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic              fifo_err,
  output logic              pop_fifo,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef FIFO_UNPACKER_LAST_EN
  output logic              out_last,
`endif
  output logic              err
);
  localparam int BEATS = FIFO_W / BEAT_W;
  localparam int CW = $clog2(BEATS);
  logic [1:0] state_q, state_d;
  logic [FIFO_W-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last;
  dff u_state [1:0]        (.clk(clk), .rst(rst), .d(state_d), .q(state_q));
  dff u_sr    [FIFO_W-1:0] (.clk(clk), .rst(rst), .d(sr_d),    .q(sr_q));
  dff u_cnt   [CW-1:0]     (.clk(clk), .rst(rst), .d(cnt_d),   .q(cnt_q));
  assign last = cnt_q == CW'(BEATS - 1);
  // next state: fetch when idle, shift on accept, reload on last beat; error overrides everything
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    pop_fifo = 1'b0;
    if (state_q == IDLE && !fifo_empty) begin
      pop_fifo = 1'b1;
      sr_d     = fifo_data;
      cnt_d    = '0;
      state_d  = SEND;
    end else if (state_q == SEND && out_ready) begin
      if (!last) begin
        sr_d  = sr_q >> BEAT_W;
        cnt_d = cnt_q + 1'b1;
      end else if (!fifo_empty) begin
        pop_fifo = 1'b1;
        sr_d     = fifo_data;
        cnt_d    = '0;
      end else begin
        sr_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
    if (fifo_err) state_d = ERR;
    if (fifo_err || !rst) pop_fifo = 1'b0;
  end
  assign out_data  = sr_q[BEAT_W-1:0];
  assign out_valid = state_q == SEND;
  assign busy      = state_q == SEND;
  assign err       = state_q == ERR;
`ifdef FIFO_UNPACKER_LAST_EN
  assign out_last  = out_valid && last;
`endif
endmodule

// File: tb/tb_fifo_unpacker.sv
// tb_fifo_unpacker: directed and random checks against a queue-based model of FIFO and beat stream
module tb_fifo_unpacker;
  localparam int BW = 16;
  localparam int NB = 64 / BW;
  logic clk = 1'b0, rst = 1'b0, fifo_empty = 1'b1, fifo_err = 1'b0, out_ready = 1'b1;
  logic pop_fifo, out_valid, busy, err;
  logic [63:0] fifo_data = '0;
  logic [BW-1:0] out_data;
`ifdef FIFO_UNPACKER_LAST_EN
  logic out_last;
`endif
  int total = 0, passed = 0, npops = 0, nvalid = 0;
  logic [63:0] fq[$];
  logic [BW-1:0] eq[$];
  bit m_err = 1'b0;

  fifo_unpacker #(.BEAT_W(BW)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_err(fifo_err),
    .pop_fifo(pop_fifo), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy),
`ifdef FIFO_UNPACKER_LAST_EN
    .out_last(out_last),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic drive();
    fifo_empty = fq.size() == 0;
    fifo_data  = fq.size() > 0 ? fq[0] : {$urandom, $urandom};
  endtask

  task automatic push(logic [63:0] w);
    fq.push_back(w);
    drive();
  endtask

  task automatic step();
    bit ep, ev;
    logic [63:0] w;
    @(negedge clk);
    ev = eq.size() > 0 && !m_err;
    ep = rst && !fifo_err && !m_err && fq.size() > 0 && (eq.size() == 0 || (eq.size() == 1 && out_ready));
    chk("pop", pop_fifo, ep);
    chk("valid", out_valid, ev);
    chk("busy", busy, ev);
    chk("err", err, m_err);
    if (ev) chk("data", out_data, eq[0]);
`ifdef FIFO_UNPACKER_LAST_EN
    chk("last", out_last, ev && eq.size() == 1);
`endif
    npops += int'(pop_fifo);
    nvalid += int'(out_valid);
    @(posedge clk);
    if (!rst) begin
      eq.delete();
      m_err = 1'b0;
    end else if (fifo_err) begin
      eq.delete();
      m_err = 1'b1;
    end else begin
      if (ev && out_ready) void'(eq.pop_front());
      if (ep) begin
        w = fq.pop_front();
        for (int i = 0; i < NB; i++) eq.push_back(w[i*BW +: BW]);
      end
    end
    #1 drive();
  endtask

  initial begin
    push(64'h4444_3333_2222_1111);
    @(posedge clk);
    #1;
    repeat (2) step();
    rst = 1'b1;
    npops = 0;
    repeat (7) step();
    chk("single_pops", npops, 1);
    npops = 0;
    nvalid = 0;
    push(64'h8888_7777_6666_5555);
    push(64'hdddd_cccc_bbbb_aaaa);
    repeat (10) step();
    chk("b2b_pops", npops, 2);
    chk("b2b_valid", nvalid, 8);
    push(64'h4444_3333_2222_1111);
    repeat (2) step();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (5) step();
    push(64'h0123_4567_89ab_cdef);
    repeat (3) step();
    fifo_err = 1'b1;
    step();
    fifo_err = 1'b0;
    push(64'hfeed_beef_cafe_f00d);
    npops = 0;
    repeat (3) step();
    chk("err_no_pop", npops, 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (6) step();
    repeat (600) begin
      if (fq.size() < 4 && $urandom_range(0, 2) == 0) push({$urandom, $urandom});
      out_ready = $urandom_range(0, 3) != 0;
      fifo_err  = $urandom_range(0, 199) == 0;
      rst       = !(m_err ? $urandom_range(0, 9) == 0 : $urandom_range(0, 299) == 0);
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
